// File: rtl/var_bw_add_pipe.sv
// Pipelined lane-splittable adder/subtractor: WIDTH-bit operands cut into 2**mode lanes.
// Latency: result registered STAGES-1 edges after the accepting edge.
// Backpressure: per-stage valid/ready; a stage holds while its successor is full and stalled.
module var_bw_add_pipe #(
  parameter int WIDTH    = 32,
  parameter int LANE_MIN = 8,
  parameter int STAGES   = 2,
  localparam int NL_MAX   = WIDTH / LANE_MIN,
  localparam int MAX_MODE = $clog2(NL_MAX),
  localparam int MODE_W   = (MAX_MODE == 0) ? 1 : $clog2(MAX_MODE + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MODE_W-1:0]        in_mode,
  input  logic                     in_sub,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+NL_MAX-1:0]  out_sum,
  output logic [MODE_W-1:0]        out_mode,
  output logic                     out_err
);

  localparam int SEG = WIDTH / STAGES;
  localparam int OW  = WIDTH + NL_MAX;
  localparam logic [MODE_W-1:0] MAX_MODE_V = MODE_W'(MAX_MODE);

  if (STAGES < 2) begin : g_bad_stages
    $error("var_bw_add_pipe needs STAGES >= 2");
  end

  // Partial result: sum bits computed so far, plus the carry out of every
  // LANE_MIN-aligned bit position. The carry leaving a segment is simply the
  // entry at the segment's top boundary, so no separate carry bit is kept.
  typedef struct packed {
    logic [WIDTH-1:0]  s;
    logic [NL_MAX-1:0] lc;
  } seg_t;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              sub;
    logic              err;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    seg_t              r;
  } stage_t;

  // Ripple one segment. The carry into any bit sitting on a lane boundary
  // (for the current lane width) is replaced by the lane carry-in.
  function automatic seg_t add_seg(input logic [MODE_W-1:0] mode, input logic sub,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input seg_t ri, input int seg);
    seg_t so;
    int   lw, bi, idx;
    logic c, bb, ci;
    so  = ri;
    lw  = WIDTH >> mode;
    idx = (seg > 0) ? (seg * SEG) / LANE_MIN - 1 : 0;
    c   = ri.lc[idx];
    for (int j = 0; j < SEG; j++) begin
      bi = seg * SEG + j;
      bb = b[bi] ^ sub;
      ci = ((bi & (lw - 1)) == 0) ? sub : c;
      so.s[bi] = a[bi] ^ bb ^ ci;
      c = (a[bi] & bb) | (a[bi] & ci) | (bb & ci);
      if (((bi + 1) % LANE_MIN) == 0) so.lc[(bi + 1) / LANE_MIN - 1] = c;
    end
    return so;
  endfunction

  // Pack each lane as {carry, sum} into Lw+1-bit slots; unused top bits stay 0.
  function automatic logic [OW-1:0] pack_lanes(input logic [MODE_W-1:0] mode, input seg_t r);
    logic [OW-1:0] o;
    o = '0;
    for (int m = 0; m <= MAX_MODE; m++) begin
      if (mode == MODE_W'(m)) begin
        for (int i = 0; i < (1 << m); i++) begin
          for (int j = 0; j < (WIDTH >> m); j++)
            o[i * ((WIDTH >> m) + 1) + j] = r.s[i * (WIDTH >> m) + j];
          o[i * ((WIDTH >> m) + 1) + (WIDTH >> m)] = r.lc[((i + 1) * (WIDTH >> m)) / LANE_MIN - 1];
        end
      end
    end
    return o;
  endfunction

  logic   [STAGES-2:0] vld_q;
  logic   [STAGES-2:0] vld_in;
  logic   [STAGES-1:0] rdy;
  stage_t              stg_q [STAGES-1];
  stage_t              stg_d [STAGES-1];
  seg_t                fin;
  logic   [OW-1:0]     sum_d;
  logic   [MODE_W-1:0] mode_eff;
  logic                mode_bad;

  // Ready chain from the output register back to the input.
  always_comb begin
    logic r;
    r = !out_valid || out_ready;
    rdy[STAGES-1] = r;
    for (int k = STAGES - 2; k >= 0; k--) begin
      r = !vld_q[k] || r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0];

  // Datapath: next contents of each intermediate stage and the packed result.
  always_comb begin
    mode_bad = in_mode > MAX_MODE_V;
    mode_eff = mode_bad ? MAX_MODE_V : in_mode;
    vld_in[0]     = in_valid;
    stg_d[0].mode = mode_eff;
    stg_d[0].sub  = in_sub;
    stg_d[0].err  = mode_bad;
    stg_d[0].a    = in_a;
    stg_d[0].b    = in_b;
    stg_d[0].r    = add_seg(mode_eff, in_sub, in_a, in_b, '0, 0);
    for (int k = 1; k < STAGES - 1; k++) begin
      vld_in[k]  = vld_q[k-1];
      stg_d[k]   = stg_q[k-1];
      stg_d[k].r = add_seg(stg_q[k-1].mode, stg_q[k-1].sub, stg_q[k-1].a, stg_q[k-1].b,
                           stg_q[k-1].r, k);
    end
    fin   = add_seg(stg_q[STAGES-2].mode, stg_q[STAGES-2].sub, stg_q[STAGES-2].a,
                    stg_q[STAGES-2].b, stg_q[STAGES-2].r, STAGES - 1);
    sum_d = pack_lanes(stg_q[STAGES-2].mode, fin);
  end

  // Stage and output registers; each advances only when it is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      for (int k = 0; k < STAGES - 1; k++) stg_q[k] <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_mode  <= '0;
      out_err   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_in[k];
          if (vld_in[k]) stg_q[k] <= stg_d[k];
        end
      end
      if (rdy[STAGES-1]) begin
        out_valid <= vld_q[STAGES-2];
        if (vld_q[STAGES-2]) begin
          out_sum  <= sum_d;
          out_mode <= stg_q[STAGES-2].mode;
          out_err  <= stg_q[STAGES-2].err;
        end
      end
    end
  end

endmodule

// File: tb/tb_var_bw_add_pipe.sv
// Bench for var_bw_add_pipe: directed vector table, stall/reset sequences,
// and randomized traffic scored against a per-lane arithmetic model.
module tb_var_bw_add_pipe;
  localparam int W  = 32;
  localparam int LM = 8;
  localparam int ST = 2;
  localparam int NL = W / LM;
  localparam int MM = 2;
  localparam int MW = 2;
  localparam int OW = W + NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sub, out_valid, out_ready, out_err;
  logic [MW-1:0] in_mode, out_mode;
  logic [W-1:0]  in_a, in_b;
  logic [OW-1:0] out_sum;

  always #5 clk = ~clk;

  var_bw_add_pipe #(.WIDTH(W), .LANE_MIN(LM), .STAGES(ST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_mode(out_mode), .out_err(out_err)
  );

  typedef struct {
    logic [MW-1:0] mode;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] sum;
    logic [MW-1:0] emode;
    logic          err;
  } vec_t;

  typedef struct {
    logic [OW-1:0] sum;
    logic [MW-1:0] mode;
    logic          err;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Lane-by-lane arithmetic: add is la+lb, sub is la-lb+2**Lw (top bit = no borrow).
  function automatic exp_t model(input logic [MW-1:0] mode, input logic sub,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int          m, lw;
    logic [63:0] mask, la, lb, r, acc;
    m    = (int'(mode) > MM) ? MM : int'(mode);
    lw   = W >> m;
    mask = (64'd1 << lw) - 64'd1;
    acc  = '0;
    for (int i = 0; i < (1 << m); i++) begin
      la  = ({32'd0, a} >> (i * lw)) & mask;
      lb  = ({32'd0, b} >> (i * lw)) & mask;
      r   = sub ? (la + (64'd1 << lw) - lb) : (la + lb);
      acc = acc | (r << (i * (lw + 1)));
    end
    e.sum  = acc[OW-1:0];
    e.mode = MW'(m);
    e.err  = int'(mode) > MM;
    return e;
  endfunction

  function automatic vec_t mk(input logic [MW-1:0] mode, input logic sub, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [OW-1:0] sum,
                              input logic [MW-1:0] emode, input logic err);
    vec_t v;
    v.mode = mode; v.sub = sub; v.a = a; v.b = b; v.sum = sum; v.emode = emode; v.err = err;
    return v;
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got unexpected result %h expected none", out_sum);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_sum", 64'(out_sum), 64'(mon_e.sum));
          chk("sb_mode", 64'(out_mode), 64'(mon_e.mode));
          chk("sb_err", 64'(out_err), 64'(mon_e.err));
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(in_mode, in_sub, in_a, in_b));
    end
  end

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_mode = v.mode; in_sub = v.sub; in_a = v.a; in_b = v.b;
  endtask

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input vec_t v, input string nm);
    bit ok;
    ok = 1'b0;
    drive(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL %s_accept: got no in_ready expected in_ready within 50 cycles", nm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result (bounded), check latency and contents, then let it pop.
  task automatic expect_out(input vec_t v, input string nm);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no out_valid expected one within 20 cycles", nm);
    end else begin
      chk({nm, "_lat"}, 64'(lat), 64'(ST));
      chk({nm, "_sum"}, 64'(out_sum), 64'(v.sum));
      chk({nm, "_mode"}, 64'(out_mode), 64'(v.emode));
      chk({nm, "_err"}, 64'(out_err), 64'(v.err));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = mk(2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {7'd0, 33'h1_0000_0000}, 2'd0, 1'b0);
    tv[1] = mk(2'd2, 1'b0, 32'hFF01_80FF, 32'h0101_8001,
               {4'd0, 9'h100, 9'h002, 9'h100, 9'h100}, 2'd2, 1'b0);
    tv[2] = mk(2'd1, 1'b1, 32'h0003_0000, 32'h0001_0001, {6'd0, 17'h1_0002, 17'h0_FFFF}, 2'd1, 1'b0);
    tv[3] = mk(2'd3, 1'b0, 32'h0000_00FF, 32'h0000_0001,
               {4'd0, 9'h000, 9'h000, 9'h000, 9'h100}, 2'd2, 1'b1);
    tv[4] = mk(2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0001_0001, {6'd0, 17'h1_0000, 17'h1_0000}, 2'd1, 1'b0);
    tv[5] = mk(2'd0, 1'b1, 32'h0000_0000, 32'h0000_0001, {7'd0, 1'b0, 32'hFFFF_FFFF}, 2'd0, 1'b0);
    tv[6] = mk(2'd2, 1'b1, 32'h0505_0505, 32'h0505_0505,
               {4'd0, 9'h100, 9'h100, 9'h100, 9'h100}, 2'd2, 1'b0);

    in_valid = 1'b0; in_mode = '0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed table, one transaction at a time.
    for (int i = 0; i < 7; i++) begin
      send(tv[i], $sformatf("tv%0d", i));
      expect_out(tv[i], $sformatf("tv%0d", i));
    end

    // Stall: three back-to-back inputs against a blocked output.
    out_ready = 1'b0;
    drive(tv[0]);
    @(negedge clk); chk("t5_rdy1", 64'(in_ready), 64'd1);
    @(posedge clk); #1; drive(tv[1]);
    @(negedge clk); chk("t5_rdy2", 64'(in_ready), 64'd1);
    @(posedge clk); #1; drive(tv[2]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_full", 64'(in_ready), 64'd0);
      chk("t5_hold_vld", 64'(out_valid), 64'd1);
      chk("t5_hold_sum", 64'(out_sum), 64'(tv[0].sum));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_o1", 64'(out_sum), 64'(tv[0].sum));
    chk("t5_pushpop", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_o2_vld", 64'(out_valid), 64'd1);
    chk("t5_o2", 64'(out_sum), 64'(tv[1].sum));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_o3_vld", 64'(out_valid), 64'd1);
    chk("t5_o3", 64'(out_sum), 64'(tv[2].sum));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    drive(tv[1]);
    @(negedge clk);
    @(posedge clk); #1; drive(tv[2]);
    @(negedge clk);
    @(posedge clk); #1; in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_vld", 64'(out_valid), 64'd0);
    chk("t6_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(tv[5], "t6_after");
    expect_out(tv[5], "t6_after");

    // Random traffic with random backpressure; scored by the monitor.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mode   = MW'($urandom_range(0, 3));
      in_sub    = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = $urandom;
      if ($urandom_range(0, 3) == 0) in_a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) in_b = in_a;
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_queue", 64'(sbq.size()), 64'd0);
    chk("drain_vld", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
